// File: rtl/rgmii_pkg.sv
// rgmii_pkg
// Shared constants for the RGMII/GMII receive framer:
//   PREAMBLE_BYTE / SFD_BYTE  - line bytes recognised ahead of the payload
//   ST_* / state_t            - framer state encoding
package rgmii_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        PRE  = ST_PRE,
        DATA = ST_DATA,
        DROP = ST_DROP
    } state_t;

endpackage

// File: rtl/lane_assembler.sv
// lane_assembler
// Turns line lanes into bytes. LANE_W=4 pairs nibbles (low nibble first),
// LANE_W=8 passes each strobed byte straight through.
//   clk, rst_n  - clock, synchronous active-low reset
//   rx_stb      - input strobe; rx_en / rx_d valid this cycle
//   rx_en       - line data-valid
//   rx_d        - line data lane
//   byte_data   - completed byte (meaningful while byte_stb=1)
//   byte_stb    - a byte completes on this strobe (combinational)
//   half        - a low nibble is held, waiting for its high nibble
module lane_assembler #(
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_stb,
    input  logic              rx_en,
    input  logic [LANE_W-1:0] rx_d,
    output logic [7:0]        byte_data,
    output logic              byte_stb,
    output logic              half
);

    logic half_q;

    // A strobe with rx_en=0 always clears the half flag; in byte mode it never sets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half_q <= 1'b0;
        end else if (rx_stb) begin
            half_q <= (LANE_W == 4) && rx_en && !half_q;
        end
    end

    assign half = half_q;

    if (LANE_W == 8) begin : g_byte
        assign byte_data = rx_d[7:0];
        assign byte_stb  = rx_stb && rx_en;
    end else begin : g_nibble
        logic [3:0] lo_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lo_q <= 4'h0;
            end else if (rx_stb && rx_en && !half_q) begin
                lo_q <= rx_d[3:0];
            end
        end

        // Byte is completed by the high nibble on the current strobe so the
        // framer can react on this very edge.
        assign byte_data = {rx_d[3:0], lo_q};
        assign byte_stb  = rx_stb && rx_en && half_q;
    end

endmodule

// File: rtl/rgmii_rx_framer.sv
// rgmii_rx_framer
// Receive framer: strips preamble/SFD, delivers payload bytes with
// valid/last/error and counts good and bad frames.
//   clk, rst_n           - clock, synchronous active-low reset
//   rx_stb, rx_en, rx_d  - sampled line strobe, data-valid and lane
//   out_data/valid/last/err - payload byte stream, one clk after the strobe
//   frame_len            - payload length of the last completed frame
//   good_cnt, bad_cnt    - wrapping frame counters
//
// state | meaning
// IDLE  | waiting for rx_en=1
// PRE   | counting preamble bytes, looking for SFD
// DATA  | payload; one byte held back to know which is last
// DROP  | discarding the rest of a bad frame until rx_en=0
module rgmii_rx_framer
    import rgmii_pkg::*;
#(
    parameter int LANE_W  = 4,
    parameter int MIN_PRE = 2,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_stb,
    input  logic              rx_en,
    input  logic [LANE_W-1:0] rx_d,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_err,
    output logic [CNT_W-1:0]  frame_len,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt
);

    localparam int PW    = (MIN_PRE < 1) ? 1 : $clog2(MIN_PRE + 1);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [PW-1:0]    MIN_PRE_C = PW'(MIN_PRE);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    logic [7:0]       byte_data;
    logic             byte_stb;
    logic             half;

    state_t           state;
    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    pre_base;
    logic [LEN_W-1:0] len;
    logic [7:0]       buf_q;
    logic             buf_full;

    lane_assembler #(.LANE_W(LANE_W)) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_stb    (rx_stb),
        .rx_en     (rx_en),
        .rx_d      (rx_d),
        .byte_data (byte_data),
        .byte_stb  (byte_stb),
        .half      (half)
    );

    // In byte mode the very first strobe already carries a preamble byte,
    // so IDLE evaluates it as PRE would with a fresh count.
    assign pre_base = (state == IDLE) ? '0 : pre_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            len       <= '0;
            buf_q     <= 8'h00;
            buf_full  <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            frame_len <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            if (rx_stb) begin
                case (state)
                    IDLE, PRE: begin
                        if (!rx_en) begin
                            state <= IDLE;
                        end else begin
                            state   <= PRE;
                            pre_cnt <= pre_base;
                            if (byte_stb) begin
                                if (byte_data == PREAMBLE_BYTE) begin
                                    if (pre_base != MIN_PRE_C) begin
                                        pre_cnt <= pre_base + PW'(1);
                                    end
                                end else if (byte_data == SFD_BYTE && pre_base >= MIN_PRE_C) begin
                                    state    <= DATA;
                                    len      <= '0;
                                    buf_full <= 1'b0;
                                end else begin
                                    state   <= DROP;
                                    bad_cnt <= bad_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (!rx_en) begin
                            state    <= IDLE;
                            buf_full <= 1'b0;
                            if (buf_full) begin
                                out_valid <= 1'b1;
                                out_data  <= buf_q;
                                out_last  <= 1'b1;
                                out_err   <= half;
                                frame_len <= CNT_W'(len);
                                if (half) begin
                                    bad_cnt <= bad_cnt + CNT_W'(1);
                                end else begin
                                    good_cnt <= good_cnt + CNT_W'(1);
                                end
                            end else begin
                                bad_cnt <= bad_cnt + CNT_W'(1);
                            end
                        end else if (byte_stb) begin
                            if (len == MAX_LEN_C) begin
                                // Held byte closes the frame as oversize.
                                out_valid <= buf_full;
                                out_data  <= buf_q;
                                out_last  <= buf_full;
                                out_err   <= buf_full;
                                frame_len <= CNT_W'(MAX_LEN_C);
                                bad_cnt   <= bad_cnt + CNT_W'(1);
                                buf_full  <= 1'b0;
                                state     <= DROP;
                            end else begin
                                if (buf_full) begin
                                    out_valid <= 1'b1;
                                    out_data  <= buf_q;
                                end
                                buf_q    <= byte_data;
                                buf_full <= 1'b1;
                                len      <= len + LEN_W'(1);
                            end
                        end
                    end
                    DROP: begin
                        if (!rx_en) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
